// File: rtl/lfgm_pkg.sv
// rtl/lfgm_pkg.sv - shared lifegame step codes, judge result codes and grid defaults
package lfgm_pkg;
    localparam int LP_GW_DEF = 80;
    localparam int LP_GH_DEF = 60;

    localparam logic LP_GN_DEAD = 1'b0;
    localparam logic LP_GN_LIVE = 1'b1;

    typedef enum logic [4:0] {
        ST_PRE_READ = 5'd0,
        ST_READ     = 5'd1,
        ST_SHIFTIN  = 5'd5,
        ST_CHK_UL   = 5'd6,
        ST_CHK_U    = 5'd7,
        ST_CHK_UR   = 5'd8,
        ST_CHK_L    = 5'd9,
        ST_CHK_R    = 5'd10,
        ST_CHK_LL   = 5'd11,
        ST_CHK_LO   = 5'd12,
        ST_CHK_LR   = 5'd13,
        ST_JDG      = 5'd14,
        ST_DLT      = 5'd15,
        ST_WRITE    = 5'd16,
        ST_WAIT     = 5'd17
    } lfgm_state_t;

    // Birth on exactly three live neighbours, survival on two or three
    function automatic logic lfgm_next_cell(input logic alive, input logic [3:0] n_live);
        return ((n_live == 4'd3) || (alive && n_live == 4'd2)) ? LP_GN_LIVE : LP_GN_DEAD;
    endfunction
endpackage

// File: rtl/lfgm_row_win.sv
// rtl/lfgm_row_win.sv - three-row capture, guarded window and neighbour extraction
module lfgm_row_win
    import lfgm_pkg::*;
#(
    parameter int GW = LP_GW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          rd_en,
    input  logic          cap_en,
    input  logic [GW-1:0] rd_data,
    input  logic          load,
    input  logic [6:0]    x,
    output logic          t_cell,
    output logic [7:0]    ad_cells
);
    logic          rd_en_q;
    logic [GW-1:0] cap_up, cap_mid, cap_lo;
    logic [GW+1:0] win_up, win_mid, win_lo;
    logic [2:0]    nb_up, nb_mid, nb_lo;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_en_q <= 1'b0;
            cap_up  <= '0;
            cap_mid <= '0;
            cap_lo  <= '0;
            win_up  <= '0;
            win_mid <= '0;
            win_lo  <= '0;
        end else begin
            rd_en_q <= rd_en;
            // Rows that were never requested come in as dead, whatever the bus holds
            if (cap_en) begin
                cap_up  <= cap_mid;
                cap_mid <= cap_lo;
                cap_lo  <= rd_en_q ? rd_data : '0;
            end
            if (load) begin
                win_up  <= {1'b0, cap_up, 1'b0};
                win_mid <= {1'b0, cap_mid, 1'b0};
                win_lo  <= {1'b0, cap_lo, 1'b0};
            end
        end
    end

    // Window column x+1 holds cell x, so the 3-wide slice at x covers x-1..x+1
    assign nb_up  = 3'(win_up >> x);
    assign nb_mid = 3'(win_mid >> x);
    assign nb_lo  = 3'(win_lo >> x);

    assign t_cell   = nb_mid[1];
    assign ad_cells = {nb_up[0], nb_up[1], nb_up[2], nb_mid[0], nb_mid[2],
                       nb_lo[0], nb_lo[1], nb_lo[2]};
endmodule

// File: rtl/lfgm_seq.sv
// rtl/lfgm_seq.sv - generation sequencer: row reads, per-cell judge stepping, row writes
module lfgm_seq
    import lfgm_pkg::*;
#(
    parameter int GW = LP_GW_DEF,
    parameter int GH = LP_GH_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          clr,
    output logic          busy,
    output logic          done,
    output logic          gen_bank,
    output logic          rd_en,
    output logic [5:0]    rd_addr,
    input  logic [GW-1:0] rd_data,
    output logic          wr_en,
    output logic [5:0]    wr_addr,
    output logic [GW-1:0] wr_data,
    output logic [4:0]    state,
    output logic          start_jdg,
    output logic          jdg_en,
    output logic          t_cell,
    output logic [7:0]    ad_cells,
    input  logic          end_jdge,
    input  logic          nxt_gen_cell,
    output logic          err
);
    localparam logic [GW-1:0] ONE = GW'(1);

    lfgm_state_t   st;
    logic [6:0]    x;
    logic [5:0]    y;
    logic [1:0]    rcnt;
    logic [GW-1:0] row_buf;
    logic          clr_lat;
    logic          y_first, y_last, x_last, cell_bit, jdg_miss;

    assign y_first  = (y == 6'd0);
    assign y_last   = (y == 6'(GH - 1));
    assign x_last   = (x == 7'(GW - 1));
    assign cell_bit = (!clr_lat && end_jdge) ? nxt_gen_cell : LP_GN_DEAD;
    assign jdg_miss = !clr_lat && !end_jdge;

    always_comb begin
        rd_en   = 1'b0;
        rd_addr = '0;
        if (st == ST_PRE_READ && !y_first) begin
            rd_en   = 1'b1;
            rd_addr = y - 6'd1;
        end else if (st == ST_READ && rcnt == 2'd0) begin
            rd_en   = 1'b1;
            rd_addr = y;
        end else if (st == ST_READ && rcnt == 2'd1 && !y_last) begin
            rd_en   = 1'b1;
            rd_addr = y + 6'd1;
        end
    end

    assign wr_en     = (st == ST_WRITE);
    assign wr_addr   = y;
    assign wr_data   = {cell_bit, row_buf[GW-2:0]};
    assign state     = st;
    assign start_jdg = (st == ST_SHIFTIN);
    assign jdg_en    = ~clr_lat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st       <= ST_WAIT;
            x        <= '0;
            y        <= '0;
            rcnt     <= '0;
            row_buf  <= '0;
            clr_lat  <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            gen_bank <= 1'b0;
            err      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                ST_WAIT: begin
                    if (start && !done) begin
                        st      <= ST_PRE_READ;
                        x       <= '0;
                        y       <= '0;
                        clr_lat <= clr;
                        err     <= 1'b0;
                        busy    <= 1'b1;
                    end
                end
                ST_PRE_READ: begin
                    st   <= ST_READ;
                    rcnt <= '0;
                end
                ST_READ: begin
                    rcnt <= rcnt + 2'd1;
                    if (rcnt == 2'd2) st <= ST_DLT;
                end
                ST_DLT: st <= ST_SHIFTIN;
                ST_SHIFTIN: begin
                    // The judge result arriving now belongs to the previous cell
                    if (x != 7'd0) begin
                        row_buf <= (row_buf & ~(ONE << (x - 7'd1))) |
                                   ({{(GW-1){1'b0}}, cell_bit} << (x - 7'd1));
                        if (jdg_miss) err <= 1'b1;
                    end
                    st <= ST_CHK_UL;
                end
                ST_CHK_UL, ST_CHK_U, ST_CHK_UR, ST_CHK_L,
                ST_CHK_R, ST_CHK_LL, ST_CHK_LO, ST_CHK_LR: begin
                    st <= lfgm_state_t'(st + 5'd1);
                end
                ST_JDG: begin
                    if (x_last) begin
                        st <= ST_WRITE;
                    end else begin
                        st <= ST_SHIFTIN;
                        x  <= x + 7'd1;
                    end
                end
                ST_WRITE: begin
                    row_buf <= {cell_bit, row_buf[GW-2:0]};
                    if (jdg_miss) err <= 1'b1;
                    if (y_last) begin
                        st       <= ST_WAIT;
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        gen_bank <= ~gen_bank;
                    end else begin
                        st <= ST_PRE_READ;
                        y  <= y + 6'd1;
                        x  <= '0;
                    end
                end
                default: st <= ST_WAIT;
            endcase
        end
    end

    lfgm_row_win #(.GW(GW)) u_win (
        .clk      (clk),
        .rst      (rst),
        .rd_en    (rd_en),
        .cap_en   (st == ST_READ),
        .rd_data  (rd_data),
        .load     (st == ST_DLT),
        .x        (x),
        .t_cell   (t_cell),
        .ad_cells (ad_cells)
    );
endmodule

// File: tb/tb_lfgm_seq.sv
// tb/tb_lfgm_seq.sv - self-checking bench for lfgm_seq
module tb_lfgm_seq;
    localparam int GW = 16;
    localparam int GH = 12;
    localparam int GEN_CYC = GH * (10 * GW + 6);

    logic          clk = 1'b0;
    logic          rst, start, clr;
    logic          busy, done, gen_bank, rd_en, wr_en;
    logic [5:0]    rd_addr, wr_addr;
    logic [GW-1:0] rd_data, wr_data;
    logic [4:0]    state;
    logic          start_jdg, jdg_en, t_cell, err;
    logic [7:0]    ad_cells;
    logic          end_jdge, nxt_gen_cell;

    lfgm_seq #(.GW(GW), .GH(GH)) dut (
        .clk(clk), .rst(rst), .start(start), .clr(clr),
        .busy(busy), .done(done), .gen_bank(gen_bank),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .state(state), .start_jdg(start_jdg), .jdg_en(jdg_en),
        .t_cell(t_cell), .ad_cells(ad_cells),
        .end_jdge(end_jdge), .nxt_gen_cell(nxt_gen_cell), .err(err)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;

    logic [GW-1:0] rmem [GH];
    logic [GW-1:0] wmem [GH];
    logic [GW-1:0] exp_rows [GH];
    bit            cur_g [GH][GW];
    logic          exp_bank;
    bit            jdg_drop = 1'b0;

    int done_cnt = 0, n_rd = 0, n_bad = 0, n_wr = 0, n_nz = 0;
    int stab_err = 0, sj_err = 0;
    logic [7:0] ad_hold;
    logic       t_hold;

    // Synchronous row memory: current generation readable, next generation captured
    always @(posedge clk) begin
        if (rd_en && rd_addr < GH) rd_data <= rmem[rd_addr];
        else rd_data <= GW'($urandom);
        if (wr_en && wr_addr < GH) begin
            wmem[wr_addr] <= wr_data;
            n_wr <= n_wr + 1;
            if (wr_data != '0) n_nz <= n_nz + 1;
        end
    end

    // Judge: answers one cycle after JDG with the life rule on the presented cells
    always @(posedge clk) begin
        if (state == 5'd14 && !jdg_drop) begin
            end_jdge     <= 1'b1;
            nxt_gen_cell <= ($countones(ad_cells) == 3) ||
                            (t_cell && $countones(ad_cells) == 2);
        end else begin
            end_jdge     <= 1'b0;
            nxt_gen_cell <= 1'($urandom);
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
        if (rd_en === 1'b1) begin
            n_rd <= n_rd + 1;
            if (rd_addr >= GH) n_bad <= n_bad + 1;
        end
        if (start_jdg !== (state == 5'd5)) sj_err <= sj_err + 1;
        if (state == 5'd5) begin
            ad_hold <= ad_cells;
            t_hold  <= t_cell;
        end else if (state >= 5'd6 && state <= 5'd14) begin
            if (ad_cells !== ad_hold || t_cell !== t_hold) stab_err <= stab_err + 1;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic load_board();
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) rmem[y][x] = cur_g[y][x];
    endtask

    task automatic clear_board();
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) cur_g[y][x] = 1'b0;
    endtask

    task automatic random_board();
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) cur_g[y][x] = ($urandom_range(0, 2) == 0);
    endtask

    // Reference: count live neighbours inside the bounded grid, apply the life rule
    task automatic model_step(input bit kill);
        int n;
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) begin
                n = 0;
                for (int dy = -1; dy <= 1; dy++)
                    for (int dx = -1; dx <= 1; dx++)
                        if ((dy != 0 || dx != 0) && y + dy >= 0 && y + dy < GH &&
                            x + dx >= 0 && x + dx < GW)
                            n += int'(cur_g[y+dy][x+dx]);
                exp_rows[y][x] = !kill && (n == 3 || (cur_g[y][x] && n == 2));
            end
    endtask

    task automatic advance_board();
        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) cur_g[y][x] = exp_rows[y][x];
    endtask

    task automatic run_gen(input bit clr_i, input bit spam, input string tag);
        int cyc, d0, r0, b0, w0, nz0, exp_nz;
        d0 = done_cnt; r0 = n_rd; b0 = n_bad; w0 = n_wr; nz0 = n_nz;
        exp_nz = 0;
        for (int y = 0; y < GH; y++) if (exp_rows[y] != '0) exp_nz++;
        @(negedge clk);
        start = 1'b1;
        clr   = clr_i;
        @(posedge clk); #1;
        start = 1'b0;
        clr   = 1'b0;
        check({tag, "_busy_accept"}, busy, 1);
        check({tag, "_err_cleared"}, err, 0);
        check({tag, "_jdg_en"}, jdg_en, !clr_i);
        check({tag, "_bank_before"}, gen_bank, exp_bank);
        cyc = 0;
        while (done !== 1'b1 && cyc < GEN_CYC + 64) begin
            if (spam) begin
                start = (cyc % 257 == 3);
                clr   = start;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0;
        clr   = 1'b0;
        check({tag, "_cycles"}, cyc, GEN_CYC);
        check({tag, "_busy_at_done"}, busy, 0);
        exp_bank = ~exp_bank;
        check({tag, "_bank_after"}, gen_bank, exp_bank);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_done_pulse"}, done, 0);
        check({tag, "_start_on_done"}, busy, 0);
        check({tag, "_wait_state"}, state, 17);
        check({tag, "_done_count"}, done_cnt - d0, 1);
        check({tag, "_reads"}, n_rd - r0, 3 * GH - 2);
        check({tag, "_bad_reads"}, n_bad - b0, 0);
        check({tag, "_writes"}, n_wr - w0, GH);
        check({tag, "_nonzero_writes"}, n_nz - nz0, exp_nz);
        for (int y = 0; y < GH; y++)
            check($sformatf("%s_row%0d", tag, y), wmem[y], exp_rows[y]);
    endtask

    typedef struct packed {
        logic [2:0]       n_in;
        logic [3:0][15:0] cin;
        logic [2:0]       n_out;
        logic [3:0][15:0] cout;
    } vec_t;

    vec_t vecs [3];

    initial begin
        logic [15:0] c;
        int cyc, w0;

        // Cells encoded {row, col}
        vecs[0].n_in = 3;  vecs[0].cin  = {16'h0000, 16'h0A0C, 16'h0A0B, 16'h0A0A};
        vecs[0].n_out = 3; vecs[0].cout = {16'h0000, 16'h0B0B, 16'h0A0B, 16'h090B};
        vecs[1].n_in = 4;  vecs[1].cin  = {16'h0101, 16'h0100, 16'h0001, 16'h0000};
        vecs[1].n_out = 4; vecs[1].cout = {16'h0101, 16'h0100, 16'h0001, 16'h0000};
        vecs[2].n_in = 2;  vecs[2].cin  = {16'h0000, 16'h0000, 16'h0B00, 16'h000F};
        vecs[2].n_out = 0; vecs[2].cout = '0;

        rst = 1'b1; start = 1'b0; clr = 1'b0;
        exp_bank = 1'b0;
        for (int y = 0; y < GH; y++) begin
            rmem[y] = '0;
            exp_rows[y] = '0;
        end
        repeat (3) @(negedge clk);
        check("rst_state", state, 17);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_gen_bank", gen_bank, 0);
        check("rst_rd_en", rd_en, 0);
        check("rst_wr_en", wr_en, 0);
        check("rst_start_jdg", start_jdg, 0);
        check("rst_jdg_en", jdg_en, 0);
        check("rst_t_cell", t_cell, 0);
        check("rst_ad_cells", ad_cells, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            clear_board();
            for (int k = 0; k < int'(vecs[i].n_in); k++) begin
                c = vecs[i].cin[k];
                cur_g[c[15:8]][c[7:0]] = 1'b1;
            end
            load_board();
            for (int y = 0; y < GH; y++) exp_rows[y] = '0;
            for (int k = 0; k < int'(vecs[i].n_out); k++) begin
                c = vecs[i].cout[k];
                exp_rows[c[15:8]][c[7:0]] = 1'b1;
            end
            run_gen(1'b0, 1'b0, $sformatf("vec%0d", i));
            check($sformatf("vec%0d_err", i), err, 0);
        end

        for (int y = 0; y < GH; y++)
            for (int x = 0; x < GW; x++) cur_g[y][x] = 1'b1;
        load_board();
        for (int y = 0; y < GH; y++) exp_rows[y] = '0;
        run_gen(1'b1, 1'b0, "clr_full");
        check("clr_full_err", err, 0);

        random_board();
        load_board();
        for (int g = 0; g < 4; g++) begin
            model_step(1'b0);
            run_gen(1'b0, g == 1, $sformatf("rnd%0d", g));
            check($sformatf("rnd%0d_err", g), err, 0);
            advance_board();
            load_board();
        end

        random_board();
        load_board();
        model_step(1'b1);
        jdg_drop = 1'b1;
        run_gen(1'b0, 1'b0, "drop");
        check("drop_err_set", err, 1);
        jdg_drop = 1'b0;
        random_board();
        load_board();
        model_step(1'b0);
        run_gen(1'b0, 1'b0, "after_drop");
        check("after_drop_err", err, 0);

        random_board();
        load_board();
        w0 = n_wr;
        @(negedge clk);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 0;
        while (n_wr - w0 < 5 && cyc < GEN_CYC) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_mid_rows_written", n_wr - w0, 5);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_state", state, 17);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_bank", gen_bank, 0);
        check("rst_mid_wr_en", wr_en, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_bank = 1'b0;
        model_step(1'b0);
        run_gen(1'b0, 1'b0, "restart");

        check("start_jdg_decode", sj_err, 0);
        check("window_stable", stab_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/lfgm_seq.md
LFGM_SEQ -- requirements
Module: lfgm_seq

Interface
REQ-001 Parameter GW, default 80: grid width in cells, 4..128.
REQ-002 Parameter GH, default 60: grid height in rows, 3..64.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-004 clk  in  1  sole clock, all logic on rising edge.
REQ-005 rst  in  1  asynchronous active-high reset.
REQ-006 start  in  1  pulse that requests one generation; honoured only in WAIT.
REQ-007 clr  in  1  sampled with start; 1 makes the whole next generation dead.
REQ-008 busy  out  1  high from the cycle after an accepted start until done.
REQ-009 done  out  1  one-cycle pulse after the last row write.
REQ-010 gen_bank  out  1  bank holding the current generation; toggles on done.
REQ-011 rd_en / rd_addr / rd_data  out 1 / out 6 / in GW  row read of bank gen_bank; rd_data valid one cycle after rd_en.
REQ-012 wr_en / wr_addr / wr_data  out 1 / out 6 / out GW  row write to bank ~gen_bank.
REQ-013 state  out  5  judge step code, shared encoding.
REQ-014 start_jdg / jdg_en / t_cell / ad_cells  out 1/1/1/8  judge drive; ad_cells[7:0] = UL,U,UR,L,R,LL,Lo,LR.
REQ-015 end_jdge / nxt_gen_cell  in 1/1  judge result, valid the cycle after state=JDG.

Function
REQ-016 State codes SHALL be WAIT=17, PRE_READ=0, READ=1, SHIFTIN=5, CHK_UL..CHK_LR=6..13, JDG=14, DLT=15, WRITE=16.
REQ-017 WAIT->PRE_READ on start; row y=0, col x=0; clr latched for the whole generation.
REQ-018 PRE_READ (1 cycle) SHALL issue a read of row y-1; READ (3 cycles) SHALL issue y then y+1 and capture the three returned rows.
REQ-019 Rows outside 0..GH-1 SHALL have no read issued (rd_en=0) and SHALL be captured as all-zero; there is no wrap-around.
REQ-020 DLT (1 cycle) SHALL latch the three rows into a 3x(GW+2) window with zero guard columns.
REQ-021 Per cell: SHIFTIN, CHK_UL..CHK_LR, JDG = 10 cycles; ad_cells and t_cell SHALL be stable for x from SHIFTIN through JDG.
REQ-022 start_jdg SHALL be 1 exactly in SHIFTIN; jdg_en SHALL equal ~clr_latched.
REQ-023 After JDG: x<GW-1 -> SHIFTIN with x+1; x=GW-1 -> WRITE.
REQ-024 In every SHIFTIN with x>0 and in WRITE, when end_jdge=1, nxt_gen_cell SHALL be stored as bit x-1 (WRITE: bit GW-1) of the row buffer.
REQ-025 WRITE (1 cycle) SHALL assert wr_en, wr_addr=y, wr_data = row buffer with bit GW-1 bypassed from nxt_gen_cell.
REQ-026 After WRITE: y<GH-1 -> PRE_READ with y+1, x=0; y=GH-1 -> WAIT with done=1 and gen_bank toggled in that same cycle.
REQ-027 A generation SHALL take exactly GH*(10*GW+6) cycles from the first PRE_READ to done.
REQ-028 start while busy SHALL be ignored; start coinciding with done is ignored.
REQ-029 end_jdge=0 where it is required (REQ-024) SHALL store a dead bit and set sticky status bit err (output, 1 bit; cleared on start).

Reset
REQ-030 rst SHALL force state=WAIT, busy=0, done=0, gen_bank=0, rd_en=0, wr_en=0, start_jdg=0, jdg_en=0, t_cell=0, ad_cells=0, err=0, counters=0.
REQ-031 rst mid-generation SHALL abandon the generation; gen_bank SHALL not toggle and the partly written bank is discarded.

Structure
REQ-032 State codes, the LP_GN_* result codes, and GW/GH defaults SHALL live in a shared lifegame package also used by the judge.
REQ-033 The 3-row window with guard columns and neighbour extraction SHALL be sub-module lfgm_row_win; the FSM, counters and write buffer stay in lfgm_seq.

Verification
REQ-034 Blinker: horizontal 3-cell line at row 10, cols 10..12 -> after one generation, vertical line at col 11, rows 9..11; all other cells dead.
REQ-035 2x2 block at the top-left corner (rows 0..1, cols 0..1) -> unchanged, no reads issued for row -1, err=0.
REQ-036 Single live cell at (0,GW-1) with a neighbour at (GH-1,0) -> both die; no wrap coupling.
REQ-037 start with clr=1 on a full board -> every wr_data=0 and done after GH*(10*GW+6) cycles.
REQ-038 rst asserted at row 5, then start -> the run restarts at row 0 and gen_bank stays 0 until the new done.
REQ-039 start pulses during busy -> ignored; exactly one done pulse.
